// File: rtl/ex_muldiv_seq_pkg.sv
// Shared types and constants for the EX-stage iterative multiply/divide sequencer.
// Op encoding mirrors funct3 of the RV64M OP/OP-32 opcodes.
package ex_muldiv_seq_pkg;

    localparam int MULDIV_XLEN   = 64;
    localparam int MULDIV_W_ITER = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/ex_muldiv_seq.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with W-variants, RISC-V divide special cases and flush abort.
module ex_muldiv_seq
    import ex_muldiv_seq_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    input  logic [2:0]      i_funct3,
    input  logic            i_word,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    input  logic            i_ready,
    output logic            o_accept,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam int WBITS = MULDIV_W_ITER;

    function automatic logic [XLEN-1:0] sext_w(input logic [WBITS-1:0] v);
        return {{(XLEN-WBITS){v[WBITS-1]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext_w(input logic [WBITS-1:0] v);
        return {{(XLEN-WBITS){1'b0}}, v};
    endfunction

    // Two's complement negate applied once when leaving CALC.
    function automatic logic [2*XLEN-1:0] sign_fix(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (-v) : v;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    muldiv_state_e     state_q,  state_d;
    muldiv_op_e        op_q,     op_d;
    logic              word_q,   word_d;
    logic              neg_q,    neg_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [XLEN-1:0]   hi_q,     hi_d;
    logic [XLEN-1:0]   lo_q,     lo_d;
    logic [XLEN-1:0]   opb_q,    opb_d;
    logic [XLEN-1:0]   result_q, result_d;

    // ------------------------------------------------------------------
    // Accept-cycle operand decode
    // ------------------------------------------------------------------
    muldiv_op_e        op_in;
    logic              is_div_in;
    logic              a_signed, b_signed;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_ext, b_ext;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN-1:0]   min_val;
    logic              div_zero, div_ovf;
    logic              neg_in;
    logic [XLEN-1:0]   special_res;

    assign op_in = muldiv_op_e'(i_funct3);

    always_comb begin
        is_div_in = i_funct3[2];
        a_signed  = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                    (op_in == OP_DIV)  || (op_in == OP_REM);
        b_signed  = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);

        a_ext = i_rs1;
        b_ext = i_rs2;
        if (i_word) begin
            a_ext = a_signed ? sext_w(i_rs1[WBITS-1:0]) : zext_w(i_rs1[WBITS-1:0]);
            b_ext = b_signed ? sext_w(i_rs2[WBITS-1:0]) : zext_w(i_rs2[WBITS-1:0]);
        end

        a_neg = a_signed & a_ext[XLEN-1];
        b_neg = b_signed & b_ext[XLEN-1];
        a_mag = a_neg ? (-a_ext) : a_ext;
        b_mag = b_neg ? (-b_ext) : b_ext;

        // Most-negative value of the operating width, as seen after extension.
        min_val = i_word ? {{(XLEN-WBITS+1){1'b1}}, {(WBITS-1){1'b0}}}
                         : {1'b1, {(XLEN-1){1'b0}}};

        div_zero = is_div_in && (b_ext == '0);
        div_ovf  = is_div_in && b_signed && (a_ext == min_val) && (b_ext == '1);

        // Remainder takes the dividend sign; quotient/product the XOR of signs.
        neg_in = (is_div_in && i_funct3[1]) ? a_neg : (a_neg ^ b_neg);

        special_res = '0;
        if (div_zero) begin
            special_res = i_funct3[1] ? a_ext : '1;
        end else if (div_ovf) begin
            special_res = i_funct3[1] ? '0 : a_ext;
        end
        if (i_word) begin
            special_res = sext_w(special_res[WBITS-1:0]);
        end
    end

    assign o_accept = i_valid && (state_q == IDLE) && !i_flush;
    assign o_busy   = (state_q != IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_result = result_q;

    // ------------------------------------------------------------------
    // One iteration of the datapath
    // ------------------------------------------------------------------
    logic              is_div_q, want_rem_q, want_low_q;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi_n, mul_lo_n;
    logic [XLEN:0]     div_rem_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [XLEN-1:0]   div_hi_n, div_lo_n;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] final_raw, final_fix;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        is_div_q   = (op_q == OP_DIV) || (op_q == OP_DIVU) ||
                     (op_q == OP_REM) || (op_q == OP_REMU);
        want_rem_q = (op_q == OP_REM) || (op_q == OP_REMU);
        want_low_q = (op_q == OP_MUL);

        // Shift-add: conditionally add multiplicand into the high half, shift right.
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        mul_hi_n = mul_sum[XLEN:1];
        mul_lo_n = {mul_sum[0], lo_q[XLEN-1:1]};

        // Restoring: bring in the next dividend bit, subtract divisor when it fits.
        div_rem_sh = {hi_q, lo_q[XLEN-1]};
        div_ge     = (div_rem_sh >= {1'b0, opb_q});
        div_sub    = div_rem_sh[XLEN-1:0] - opb_q;
        div_hi_n   = div_ge ? div_sub : div_rem_sh[XLEN-1:0];
        div_lo_n   = {lo_q[XLEN-2:0], div_ge};

        step_hi = is_div_q ? div_hi_n : mul_hi_n;
        step_lo = is_div_q ? div_lo_n : mul_lo_n;

        if (is_div_q) begin
            final_raw = {{XLEN{1'b0}}, (want_rem_q ? step_hi : step_lo)};
        end else begin
            final_raw = {step_hi, step_lo};
            // A 32-iteration multiply leaves the product 32 bits up.
            if (word_q) begin
                final_raw = final_raw >> WBITS;
            end
        end

        final_fix = sign_fix(final_raw, neg_q);
        final_res = (is_div_q || want_low_q || word_q) ? final_fix[XLEN-1:0]
                                                        : final_fix[2*XLEN-1:XLEN];
        if (word_q) begin
            final_res = sext_w(final_res[WBITS-1:0]);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        word_d   = word_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (o_accept) begin
                    op_d   = op_in;
                    word_d = i_word;
                    neg_d  = neg_in;
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        cnt_d   = i_word ? CNT_W'(WBITS - 1) : CNT_W'(XLEN - 1);
                        hi_d    = '0;
                        state_d = CALC;
                        if (is_div_in) begin
                            // Dividend MSB must sit at the top of lo for the shift-in.
                            lo_d  = i_word ? (a_mag << WBITS) : a_mag;
                            opb_d = b_mag;
                        end else begin
                            lo_d  = b_mag;
                            opb_d = a_mag;
                        end
                    end
                end
            end
            CALC: begin
                hi_d = step_hi;
                lo_d = step_lo;
                if (cnt_q == '0) begin
                    result_d = final_res;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (i_flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            word_q   <= word_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: arithmetic results, latencies, special cases,
// flush, hold-in-DONE and mid-operation reset.
module tb_ex_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [2:0]  i_funct3 = 3'd0;
    logic        i_word = 1'b0;
    logic [63:0] i_rs1 = '0;
    logic [63:0] i_rs2 = '0;
    logic        i_flush = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_accept;
    logic        o_busy;
    logic        o_valid;
    logic [63:0] o_result;

    int checks = 0;
    int failures = 0;

    ex_muldiv_seq #(.XLEN(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .i_funct3 (i_funct3),
        .i_word   (i_word),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_flush  (i_flush),
        .i_ready  (i_ready),
        .o_accept (o_accept),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    always #5 clk = ~clk;

    // Issues one op, waits (bounded) for o_valid; lat = -1 if never accepted/completed.
    task automatic do_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input bit consume,
                         output logic [63:0] res, output int lat);
        res = '0;
        lat = -1;
        @(negedge clk);
        i_funct3 = f3; i_word = w; i_rs1 = a; i_rs2 = b; i_valid = 1'b1;
        #1;
        for (int n = 0; n < 8 && !o_accept; n++) begin
            @(negedge clk);
            #1;
        end
        if (!o_accept) begin
            i_valid = 1'b0;
            $display("txn f3=%0d w=%0b a=%h b=%h not accepted", f3, w, a, b);
            return;
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (o_valid) begin
                lat = k;
                res = o_result;
                break;
            end
        end
        $display("txn f3=%0d w=%0b a=%h b=%h res=%h lat=%0d", f3, w, a, b, res, lat);
        if (consume && lat > 0) begin
            i_ready = 1'b1;
            @(posedge clk);
            #1;
            i_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_busy, o_valid, o_accept, o_result} !== 67'd0) begin
            failures++;
            $display("FAIL reset: got busy=%b valid=%b accept=%b result=%h expected all 0",
                     o_busy, o_valid, o_accept, o_result);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic [2:0]  vf [4] = '{3'd0, 3'd3, 3'd1, 3'd2};
        logic [63:0] va [4] = '{64'd7, '1, '1, '1};
        logic [63:0] vb [4] = '{64'hFFFF_FFFF_FFFF_FFFD, '1, '1, 64'd2};
        logic [63:0] ve [4] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, '1};
        logic [63:0] res;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(vf[i], 1'b0, va[i], vb[i], 1'b1, res, lat);
            checks++;
            if (res !== ve[i]) begin
                failures++;
                $display("FAIL mul[%0d] result: got %h expected %h", i, res, ve[i]);
            end
            checks++;
            if (lat !== 65) begin
                failures++;
                $display("FAIL mul[%0d] latency: got %0d expected 65", i, lat);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  vf [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [63:0] va [4] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd100, 64'd100};
        logic [63:0] vb [4] = '{64'd2, 64'd2, 64'd7, 64'd7};
        logic [63:0] ve [4] = '{64'hFFFF_FFFF_FFFF_FFFD, '1, 64'd14, 64'd2};
        logic [63:0] res;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(vf[i], 1'b0, va[i], vb[i], 1'b1, res, lat);
            checks++;
            if (res !== ve[i]) begin
                failures++;
                $display("FAIL div[%0d] result: got %h expected %h", i, res, ve[i]);
            end
            checks++;
            if (lat !== 65) begin
                failures++;
                $display("FAIL div[%0d] latency: got %0d expected 65", i, lat);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  vf [4] = '{3'd4, 3'd6, 3'd4, 3'd6};
        logic [63:0] va [4] = '{64'd5, 64'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        logic [63:0] vb [4] = '{64'd0, 64'd0, '1, '1};
        logic [63:0] ve [4] = '{'1, 64'd5, 64'h8000_0000_0000_0000, 64'd0};
        logic [63:0] res;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(vf[i], 1'b0, va[i], vb[i], 1'b1, res, lat);
            checks++;
            if (res !== ve[i]) begin
                failures++;
                $display("FAIL special[%0d] result: got %h expected %h", i, res, ve[i]);
            end
            checks++;
            if (lat !== 1) begin
                failures++;
                $display("FAIL special[%0d] latency: got %0d expected 1", i, lat);
            end
        end
    endtask

    task automatic test_word();
        logic [2:0]  vf [4] = '{3'd4, 3'd0, 3'd6, 3'd5};
        logic [63:0] va [4] = '{64'h1_8000_0000, 64'h7FFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF};
        logic [63:0] vb [4] = '{'1, 64'd2, 64'd2, 64'd1};
        logic [63:0] ve [4] = '{64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFE, '1, '1};
        int          vl [4] = '{1, 33, 33, 33};
        logic [63:0] res;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(vf[i], 1'b1, va[i], vb[i], 1'b1, res, lat);
            checks++;
            if (res !== ve[i]) begin
                failures++;
                $display("FAIL word[%0d] result: got %h expected %h", i, res, ve[i]);
            end
            checks++;
            if (lat !== vl[i]) begin
                failures++;
                $display("FAIL word[%0d] latency: got %0d expected %0d", i, lat, vl[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [63:0] res;
        int lat;
        bit seen_valid = 1'b0;
        @(negedge clk);
        i_funct3 = 3'd4; i_word = 1'b0; i_rs1 = 64'd1000; i_rs2 = 64'd3; i_valid = 1'b1;
        #1;
        checks++;
        if (o_accept !== 1'b1) begin
            failures++;
            $display("FAIL flush_start accept: got %b expected 1", o_accept);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        checks++;
        if ({o_busy, o_valid} !== 2'b00) begin
            failures++;
            $display("FAIL flush: got busy=%b valid=%b expected 0 0", o_busy, o_valid);
        end
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (o_valid) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_result: got o_valid seen=%b expected 0", seen_valid);
        end
        $display("txn flush aborted DIV 1000/3");
        do_op(3'd5, 1'b0, 64'd9, 64'd3, 1'b1, res, lat);
        checks++;
        if (res !== 64'd3 || lat !== 65) begin
            failures++;
            $display("FAIL after_flush DIVU: got %h lat %0d expected 3 lat 65", res, lat);
        end
    endtask

    task automatic test_flush_accept();
        @(negedge clk);
        i_funct3 = 3'd0; i_word = 1'b0; i_rs1 = 64'd3; i_rs2 = 64'd4;
        i_valid = 1'b1; i_flush = 1'b1;
        #1;
        checks++;
        if (o_accept !== 1'b0) begin
            failures++;
            $display("FAIL flush_accept: got accept=%b expected 0", o_accept);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0; i_flush = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_accept busy: got %b expected 0", o_busy);
        end
        $display("txn valid+flush same cycle, not accepted");
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        int lat;
        do_op(3'd0, 1'b0, 64'd6, 64'd7, 1'b0, res, lat);
        checks++;
        if (res !== 64'd42 || lat !== 65) begin
            failures++;
            $display("FAIL hold_op: got %h lat %0d expected 2a lat 65", res, lat);
        end
        i_funct3 = 3'd3; i_rs1 = 64'd5; i_rs2 = 64'd5; i_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (o_valid !== 1'b1 || o_result !== 64'd42 || o_accept !== 1'b0) begin
                failures++;
                $display("FAIL hold[%0d]: got valid=%b result=%h accept=%b expected 1 2a 0",
                         c, o_valid, o_result, o_accept);
            end
            @(negedge clk);
        end
        i_ready = 1'b1;
        #1;
        checks++;
        if (o_accept !== 1'b0) begin
            failures++;
            $display("FAIL b2b accept in DONE: got %b expected 0", o_accept);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        checks++;
        if ({o_busy, o_valid} !== 2'b00) begin
            failures++;
            $display("FAIL b2b consume: got busy=%b valid=%b expected 0 0", o_busy, o_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (o_accept !== 1'b1) begin
            failures++;
            $display("FAIL b2b accept in IDLE: got %b expected 1", o_accept);
        end
        i_valid = 1'b0;
        $display("txn hold 5 cycles then consume, result=%h", o_result);
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int lat;
        @(negedge clk);
        i_funct3 = 3'd4; i_word = 1'b0; i_rs1 = 64'd12345; i_rs2 = 64'd7; i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_valid, o_accept, o_result} !== 67'd0) begin
            failures++;
            $display("FAIL reset_mid: got busy=%b valid=%b accept=%b result=%h expected all 0",
                     o_busy, o_valid, o_accept, o_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset asserted mid DIV");
        do_op(3'd5, 1'b0, 64'd9, 64'd3, 1'b1, res, lat);
        checks++;
        if (res !== 64'd3 || lat !== 65) begin
            failures++;
            $display("FAIL after_reset DIVU: got %h lat %0d expected 3 lat 65", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_word();
        test_flush();
        test_flush_accept();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
